// File: rtl/game_controller_if.sv
// Frame-rate control and status bundle between the block-dodger game engine and its environment.
interface game_controller_if;
    logic        frame_tick;
    logic        btn_left;
    logic        btn_right;
    logic        btn_start;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [9:0]  block0_x;
    logic [9:0]  block0_y;
    logic [9:0]  block1_x;
    logic [9:0]  block1_y;
    logic [9:0]  block2_x;
    logic [9:0]  block2_y;
    logic [1:0]  state;
    logic        game_over;
    logic [15:0] score;

    modport master (
        output frame_tick, btn_left, btn_right, btn_start,
        input  player_x, player_y, block0_x, block0_y, block1_x, block1_y,
               block2_x, block2_y, state, game_over, score
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_start,
        output player_x, player_y, block0_x, block0_y, block1_x, block1_y,
               block2_x, block2_y, state, game_over, score
    );
endinterface

// File: rtl/game_controller.sv
// Block-dodger game engine: title/play/over FSM, player motion, falling blocks with
// LFSR respawn, collision and score. All outputs update once per frame_tick.
module game_controller #(
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter int          PLAYER_W    = 110,
    parameter int          PLAYER_H    = 20,
    parameter int          BLOCK_W     = 110,
    parameter int          BLOCK_H     = 32,
    parameter int          PLAYER_Y    = 440,
    parameter int          PLAYER_STEP = 4,
    parameter int          BASE_SPEED  = 2,
    parameter int          MAX_SPEED   = 8,
    parameter int          SPAWN_GAP   = 160,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    game_controller_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_OVER = 2'd2} state_t;

    localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BLOCK_W);
    localparam logic [9:0]  X_HOME   = 10'((SCREEN_W - PLAYER_W) / 2);
    localparam logic [9:0]  Y_PARK   = 10'(SCREEN_H);
    localparam logic [9:0]  Y_PLAYER = 10'(PLAYER_Y);
    localparam logic [10:0] H_LIM    = 11'(SCREEN_H);
    localparam logic [10:0] P_W      = 11'(PLAYER_W);
    localparam logic [10:0] P_H      = 11'(PLAYER_H);
    localparam logic [10:0] B_W      = 11'(BLOCK_W);
    localparam logic [10:0] B_H      = 11'(BLOCK_H);
    localparam logic [10:0] P_Y      = 11'(PLAYER_Y);
    localparam logic [10:0] STEP     = 11'(PLAYER_STEP);
    localparam logic [10:0] GAP      = 11'(SPAWN_GAP);
    localparam logic [15:0] SPD_BASE = 16'(BASE_SPEED);
    localparam logic [15:0] SPD_MAX  = 16'(MAX_SPEED);

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Ten LFSR bits per block; values past the right edge fold back by 512.
    function automatic logic [9:0] spawn_x(input logic [15:0] lf, input int k);
        logic [10:0] c;
        c = {1'b0, lf[3*k +: 10]};
        return (c <= X_MAX) ? c[9:0] : 10'(c - 11'd512);
    endfunction

    state_t      r_state, w_state;
    logic [9:0]  r_px, w_px;
    logic [9:0]  r_bx [3];
    logic [9:0]  w_bx [3];
    logic [9:0]  r_by [3];
    logic [9:0]  w_by [3];
    logic [2:0]  r_act, w_act;
    logic [15:0] r_score, w_score;
    logic [15:0] r_lfsr;
    logic        r_btn_prev, r_start_req, r_game_over;
    logic        w_start_edge, w_req, w_coll;
    logic [15:0] w_spd_raw;
    logic [10:0] w_speed, w_px11;
    logic [10:0] w_ny [3];
    logic [2:0]  w_hit;
    logic [1:0]  w_inc;
    logic [16:0] w_sum;

    assign w_start_edge = bus.btn_start & ~r_btn_prev;
    assign w_req        = r_start_req | w_start_edge;
    assign w_spd_raw    = SPD_BASE + (r_score >> 3);
    assign w_speed      = (w_spd_raw > SPD_MAX) ? SPD_MAX[10:0] : w_spd_raw[10:0];
    assign w_px11       = {1'b0, r_px};
    assign w_coll       = |w_hit;

    // Per-block overlap test and candidate fall position, from pre-update registers.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_ny[k]  = {1'b0, r_by[k]} + w_speed;
            w_hit[k] = r_act[k]
                     & ({1'b0, r_bx[k]} < w_px11 + P_W)
                     & (w_px11 < {1'b0, r_bx[k]} + B_W)
                     & ({1'b0, r_by[k]} < P_Y + P_H)
                     & (P_Y < {1'b0, r_by[k]} + B_H);
        end
    end

    // Next-state and next-frame values; everything holds except on frame_tick.
    always_comb begin
        w_state = r_state;
        w_px    = r_px;
        w_bx    = r_bx;
        w_by    = r_by;
        w_act   = r_act;
        w_score = r_score;
        w_inc   = 2'd0;
        w_sum   = {1'b0, r_score};
        if (bus.frame_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        w_state = ST_PLAY;
                        w_score = 16'd0;
                        w_px    = X_HOME;
                        w_act   = 3'b001;
                        for (int k = 1; k < 3; k++) begin
                            w_bx[k] = 10'd0;
                            w_by[k] = Y_PARK;
                        end
                        w_bx[0] = spawn_x(r_lfsr, 0);
                        w_by[0] = 10'd0;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (w_coll) begin
                        w_state = ST_OVER;
                    end else begin
                        if (bus.btn_left && !bus.btn_right) begin
                            w_px = (w_px11 >= STEP) ? 10'(w_px11 - STEP) : 10'd0;
                        end else if (bus.btn_right && !bus.btn_left) begin
                            w_px = (w_px11 + STEP > X_MAX) ? X_MAX[9:0] : 10'(w_px11 + STEP);
                        end else begin
                            w_px = r_px;
                        end
                        for (int k = 0; k < 3; k++) begin
                            if (r_act[k]) begin
                                if (w_ny[k] >= H_LIM) begin
                                    w_by[k] = 10'd0;
                                    w_bx[k] = spawn_x(r_lfsr, k);
                                    w_inc   = w_inc + 2'd1;
                                end else begin
                                    w_by[k] = w_ny[k][9:0];
                                end
                            end else begin
                                w_by[k] = r_by[k];
                            end
                        end
                        // Activation looks at the predecessor's pre-update state only.
                        for (int k = 1; k < 3; k++) begin
                            if (!r_act[k] && r_act[k-1] && ({1'b0, r_by[k-1]} >= GAP)) begin
                                w_act[k] = 1'b1;
                                w_by[k]  = 10'd0;
                                w_bx[k]  = spawn_x(r_lfsr, k);
                            end else begin
                                w_act[k] = r_act[k];
                            end
                        end
                        w_sum   = {1'b0, r_score} + 17'(w_inc);
                        w_score = w_sum[16] ? 16'hFFFF : w_sum[15:0];
                    end
                end
                ST_OVER: begin
                    if (w_req) begin
                        w_state = ST_IDLE;
                        w_px    = X_HOME;
                        w_act   = 3'b000;
                        for (int k = 0; k < 3; k++) begin
                            w_bx[k] = 10'd0;
                            w_by[k] = Y_PARK;
                        end
                    end else begin
                        w_state = ST_OVER;
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end else begin
            w_state = r_state;
        end
    end

    // Game registers, free-running LFSR and sticky start request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_game_over <= 1'b0;
            r_px        <= X_HOME;
            r_act       <= 3'b000;
            r_score     <= 16'd0;
            r_lfsr      <= LFSR_SEED;
            r_btn_prev  <= 1'b0;
            r_start_req <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_bx[k] <= 10'd0;
                r_by[k] <= Y_PARK;
            end
        end else begin
            r_lfsr      <= lfsr_step(r_lfsr);
            r_btn_prev  <= bus.btn_start;
            r_start_req <= bus.frame_tick ? 1'b0 : w_req;
            r_state     <= w_state;
            r_game_over <= (w_state == ST_OVER);
            r_px        <= w_px;
            r_act       <= w_act;
            r_score     <= w_score;
            r_bx        <= w_bx;
            r_by        <= w_by;
        end
    end

    assign bus.player_x  = r_px;
    assign bus.player_y  = Y_PLAYER;
    assign bus.block0_x  = r_bx[0];
    assign bus.block0_y  = r_by[0];
    assign bus.block1_x  = r_bx[1];
    assign bus.block1_y  = r_by[1];
    assign bus.block2_x  = r_bx[2];
    assign bus.block2_y  = r_by[2];
    assign bus.state     = r_state;
    assign bus.game_over = r_game_over;
    assign bus.score     = r_score;
endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a frame-level reference model and autopilot steering.
module tb_game_controller;
    logic clk;
    logic rst_n;
    game_controller_if bus ();
    game_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    logic [15:0] tb_lfsr;

    int m_state, m_px, m_score, m_sp, m_inc;
    int m_bx [3];
    int m_by [3];
    bit m_act [3];
    bit m_req, prev_btn, m_moved0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Reference LFSR, reset and clocked exactly like the design's generator.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_lfsr <= 16'hACE1;
        else        tb_lfsr <= lfsr_next(tb_lfsr);
    end

    function automatic int x_of(input logic [15:0] lf, input int k);
        int c;
        c = (int'(lf) >> (3 * k)) & 1023;
        return (c <= 530) ? c : c - 512;
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic park_all();
        for (int k = 0; k < 3; k++) begin
            m_act[k] = 1'b0;
            m_bx[k]  = 0;
            m_by[k]  = 480;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_px = 265; m_score = 0; m_req = 1'b0; prev_btn = 1'b0;
        park_all();
    endtask

    task automatic model_tick(input bit req, input logic [15:0] lf, input bit l, input bit r);
        int oby [3];
        bit oact [3];
        bit coll;
        m_inc = 0; m_moved0 = 1'b0;
        if (m_state == 0) begin
            if (req) begin
                m_state = 1; m_score = 0; m_px = 265; park_all();
                m_act[0] = 1'b1; m_by[0] = 0; m_bx[0] = x_of(lf, 0);
            end
        end else if (m_state == 1) begin
            coll = 1'b0;
            for (int k = 0; k < 3; k++)
                if (m_act[k] && m_bx[k] < m_px + 110 && m_px < m_bx[k] + 110 &&
                    m_by[k] < 460 && 440 < m_by[k] + 32) coll = 1'b1;
            if (coll) m_state = 2;
            else begin
                if (l && !r) m_px = (m_px - 4 < 0) ? 0 : m_px - 4;
                else if (r && !l) m_px = (m_px + 4 > 530) ? 530 : m_px + 4;
                m_sp = 2 + m_score / 8;
                if (m_sp > 8) m_sp = 8;
                oby = m_by; oact = m_act;
                for (int k = 0; k < 3; k++) begin
                    if (oact[k]) begin
                        if (m_by[k] + m_sp >= 480) begin
                            m_by[k] = 0; m_bx[k] = x_of(lf, k); m_inc++;
                        end else begin
                            m_by[k] = m_by[k] + m_sp;
                            if (k == 0) m_moved0 = 1'b1;
                        end
                    end
                end
                for (int k = 1; k < 3; k++)
                    if (!oact[k] && oact[k-1] && oby[k-1] >= 160) begin
                        m_act[k] = 1'b1; m_by[k] = 0; m_bx[k] = x_of(lf, k);
                    end
                m_score = (m_score + m_inc > 65535) ? 65535 : m_score + m_inc;
            end
        end else begin
            if (req) begin
                m_state = 0; m_px = 265; park_all();
            end
        end
    endtask

    task automatic check_all();
        check_val("state", int'(bus.state), m_state);
        check_val("game_over", int'(bus.game_over), int'(m_state == 2));
        check_val("player_x", int'(bus.player_x), m_px);
        check_val("player_y", int'(bus.player_y), 440);
        check_val("block0_x", int'(bus.block0_x), m_bx[0]);
        check_val("block0_y", int'(bus.block0_y), m_by[0]);
        check_val("block1_x", int'(bus.block1_x), m_bx[1]);
        check_val("block1_y", int'(bus.block1_y), m_by[1]);
        check_val("block2_x", int'(bus.block2_x), m_bx[2]);
        check_val("block2_y", int'(bus.block2_y), m_by[2]);
        check_val("score", int'(bus.score), m_score);
    endtask

    task automatic press_start();
        @(negedge clk);
        bus.btn_start = 1'b1;
        if (!prev_btn) m_req = 1'b1;
        prev_btn = 1'b1;
        @(negedge clk);
        bus.btn_start = 1'b0;
        prev_btn = 1'b0;
    endtask

    task automatic do_tick(input bit l, input bit r, input bit s);
        int b0_before, s_before;
        bit req;
        @(negedge clk);
        b0_before = int'(bus.block0_y);
        s_before  = int'(bus.score);
        bus.btn_left = l; bus.btn_right = r; bus.btn_start = s; bus.frame_tick = 1'b1;
        req = m_req | (s & ~prev_btn);
        prev_btn = s; m_req = 1'b0;
        model_tick(req, tb_lfsr, l, r);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        check_all();
        if (m_inc > 0) check_val("score_step", int'(bus.score) - s_before, m_inc);
        if (m_moved0) check_val("b0_fall", int'(bus.block0_y) - b0_before, m_sp);
    endtask

    // Steer relative to the nearest block still able to hit: dodge it, or hunt it.
    task automatic pick(input bit hunt, output bit l, output bit r);
        int best, bx;
        best = -1; l = 1'b0; r = 1'b0;
        for (int k = 0; k < 3; k++)
            if (m_act[k] && m_by[k] < 460 && (best < 0 || m_by[k] > m_by[best])) best = k;
        if (best >= 0 && m_state == 1) begin
            bx = m_bx[best];
            if (hunt) begin
                l = (m_px > bx); r = (m_px < bx);
            end else if (!(m_px + 110 <= bx || m_px >= bx + 110)) begin
                if (bx < 110) r = 1'b1;
                else if (bx + 110 > 530) l = 1'b1;
                else if (m_px - (bx - 110) <= (bx + 110) - m_px) l = 1'b1;
                else r = 1'b1;
            end
        end
    endtask

    initial begin
        bit l, r;
        int guard, held, px_over;
        n_checks = 0; n_errors = 0;
        bus.frame_tick = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_start = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        do_tick(0, 0, 0);

        // Game A: start, movement, clamp, activation, then autopilot to score 9.
        press_start();
        do_tick(0, 0, 0);
        check_val("start_state", int'(bus.state), 1);
        check_val("start_b0y", int'(bus.block0_y), 0);
        check_val("start_b0x_range", int'(bus.block0_x <= 10'd530), 1);
        do_tick(0, 0, 0);
        check_val("second_b0y", int'(bus.block0_y), 2);
        repeat (2) do_tick(1, 1, 0);
        check_val("both_hold", int'(bus.player_x), 265);
        do_tick(1, 0, 0);
        check_val("left_step", int'(bus.player_x), 261);
        repeat (69) do_tick(1, 0, 0);
        check_val("left_clamp", int'(bus.player_x), 0);
        repeat (7) do_tick(0, 0, 0);
        check_val("gap_b0y", int'(bus.block0_y), 160);
        check_val("gap_b1_parked", int'(bus.block1_y), 480);
        do_tick(0, 0, 0);
        check_val("b1_active", int'(bus.block1_y), 0);
        check_val("b0_after_gap", int'(bus.block0_y), 162);
        guard = 0;
        while (m_score < 9 && m_state == 1 && guard < 4000) begin
            pick(1'b0, l, r);
            do_tick(l, r, 0);
            guard++;
        end
        check_val("score_reached", int'(bus.score >= 16'd9), 1);

        // Collision, freeze, restart via IDLE, then start edge on the tick.
        guard = 0;
        while (m_state == 1 && guard < 800) begin
            pick(1'b1, l, r);
            do_tick(l, r, 0);
            guard++;
        end
        check_val("over_state", int'(bus.state), 2);
        check_val("over_flag", int'(bus.game_over), 1);
        held = m_score; px_over = m_px;
        repeat (3) do_tick(0, 1, 0);
        check_val("frozen_px", int'(bus.player_x), px_over);
        press_start();
        do_tick(0, 0, 0);
        check_val("idle_state", int'(bus.state), 0);
        check_val("score_held", int'(bus.score), held);
        do_tick(0, 0, 1);
        check_val("tick_edge_state", int'(bus.state), 1);
        check_val("restart_score", int'(bus.score), 0);

        // Game B: right clamp with start held; collide; held start must not retrigger.
        repeat (140) do_tick(0, 1, 1);
        check_val("right_clamp", int'(bus.player_x), 530);
        repeat (60) begin
            pick(1'b0, l, r);
            do_tick(l, r, 1);
        end
        guard = 0;
        while (m_state == 1 && guard < 800) begin
            pick(1'b1, l, r);
            do_tick(l, r, 1);
            guard++;
        end
        repeat (3) do_tick(0, 0, 1);
        check_val("no_retrigger", int'(bus.state), 2);
        do_tick(0, 0, 0);
        press_start();
        do_tick(0, 0, 0);
        press_start();
        do_tick(0, 0, 0);
        check_val("replay_state", int'(bus.state), 1);
        repeat (5) do_tick(0, 1, 0);

        // Asynchronous reset in the middle of a clock phase during PLAY.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_state", int'(bus.state), 0);
        check_val("rst_px", int'(bus.player_x), 265);
        check_val("rst_py", int'(bus.player_y), 440);
        check_val("rst_b0y", int'(bus.block0_y), 480);
        check_val("rst_b1y", int'(bus.block1_y), 480);
        check_val("rst_b2y", int'(bus.block2_y), 480);
        check_val("rst_score", int'(bus.score), 0);
        check_val("rst_go", int'(bus.game_over), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_tick(0, 0, 0);
        check_val("post_rst_idle", int'(bus.state), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/game_controller.md
# game_controller

Game-state and physics engine for the block-dodger. It owns the title/play/game-over state machine, player movement from the push-buttons, falling-block motion with pseudo-random respawn, collision detection and scoring. It sits directly upstream of the pixel renderer and drives its `player_*`, `block*_*`, `state` and `game_over` inputs. All outputs are registered and change only once per video frame.

## Interface
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height; also the parked y of inactive blocks.
- `PLAYER_W`, 110: player width. `PLAYER_H`, 20: player height.
- `BLOCK_W`, 110: block width. `BLOCK_H`, 32: block height.
- `PLAYER_Y`, 440: fixed player y.
- `PLAYER_STEP`, 4: player pixels per frame.
- `BASE_SPEED`, 2: initial block pixels per frame. `MAX_SPEED`, 8: speed cap.
- `SPAWN_GAP`, 160: predecessor y at which the next block activates.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, at vblank start.
- `btn_left`, `btn_right`, `btn_start` in 1 each: synchronized, debounced levels.
- `player_x`, `player_y` out 10: player top-left corner.
- `block0_x`, `block0_y`, `block1_x`, `block1_y`, `block2_x`, `block2_y` out 10 each: block top-left corners.
- `state` out 2: 0 IDLE, 1 PLAY, 2 OVER. The value 3 never occurs.
- `game_over` out 1: high exactly when `state` is 2.
- `score` out 16: blocks dodged, saturating at 65535.

## Operation
- **Reset values**:
  - `state` is 0 and `score` is 0.
  - `player_x` = (SCREEN_W−PLAYER_W)/2 = 265 and `player_y` = PLAYER_Y.
  - All blocks are inactive, with x = 0 and y = SCREEN_H.
  - The LFSR holds LFSR_SEED and the start request is cleared.
- **LFSR**:
  - 16-bit Galois register with feedback mask 16'hB400, advanced every clock in every state.
  - Block k takes c = lfsr[3k+9:3k] for k = 0, 1, 2.
  - x = c when c ≤ SCREEN_W−BLOCK_W (530), otherwise x = c−512.
- **Start request**: a rising edge of `btn_start` (the button is high now and was low on the previous clock) sets a sticky request. Every `frame_tick` clears it. An edge arriving in the same cycle as `frame_tick` counts for that tick.
- **Update rule**: everything below is evaluated only on `frame_tick` cycles. Between ticks all outputs hold.
- **IDLE**:
  - With the start request set, go to PLAY.
  - `score` is cleared and `player_x` is set to 265.
  - Block0 becomes active with y = 0 and its LFSR-derived x. Blocks 1 and 2 are parked.
- **PLAY, collision check**:
  - The check uses current (pre-update) register values.
  - A collision is an active block k with bx < px+PLAYER_W, px < bx+BLOCK_W, by < PLAYER_Y+PLAYER_H and PLAYER_Y < by+BLOCK_H.
  - If any block collides, go to OVER, freeze all positions and apply no updates on this tick.
- **PLAY, no collision**:
  - Player:
    - Left only: x = max(x−STEP, 0).
    - Right only: x = min(x+STEP, 530).
    - Both pressed or neither pressed: hold.
  - Active blocks: ny = y + speed.
    - If ny ≥ SCREEN_H, the block respawns with y = 0 and its new LFSR x, and `score` increments by 1.
    - Several respawns on the same tick add their count to `score`.
    - Otherwise y = ny.
  - Activation of block k (k = 1, 2): if it is inactive, block k−1 is active and the pre-update y of block k−1 is ≥ SPAWN_GAP, block k activates with y = 0 and its LFSR x.
  - The start request is ignored.
- **Speed**: speed = min(BASE_SPEED + (score>>3), MAX_SPEED), computed from the registered `score`. A new score therefore affects motion from the following tick.
- **OVER**: all positions and `score` are frozen. With the start request set, go to IDLE; positions take their reset values and `score` is kept.
- **Width rules**: all position arithmetic is done at 11 bits before comparison or clamping, so no 10-bit wrap occurs.

## Timing
- Latency from `frame_tick` to the new outputs is 1 cycle (the outputs are registered on the tick edge). Outputs are stable for the whole active video period.
- A collision is detected on the first tick at which the overlap exists in the registered positions, so at most one frame after it is first drawn.
- `rst_n` assertion takes effect immediately, in any state and mid-frame. Release is synchronous to `clk`, and the first tick after release sees IDLE.

## Test plan
- **Reset**: assert `rst_n`=0 mid-PLAY → asynchronously, `state`=0, `player_x`=265, `player_y`=440, all block y = 480, `score`=0, `game_over`=0.
- **Start**:
  - Pulse `btn_start` between ticks, then apply `frame_tick` → one cycle later `state`=1, `block0_y`=0, and `block0_x` equals the reference-model LFSR value, within 0..530.
  - On the next tick `block0_y`=2.
  - When `block0_y` first reaches ≥160, block1 activates with y=0 on the following tick.
- **Player clamp**:
  - Hold right for 140 ticks → `player_x` stops at exactly 530.
  - Hold left → decreases by 4 per tick and stops at 0.
  - Both buttons held → unchanged.
- **Respawn and score**: steer the player away using the LFSR model. When block0 passes y ≥ 480 → y=0 with a new x and `score`+1. At `score`=8 the block step becomes 3. Two blocks respawning on the same tick → `score`+2.
- **Collision**: steer the player under a block → on the first overlapping tick `state`=2 and `game_over`=1, with positions identical on later ticks. Start → `state`=0 with `score` held. Start again → `state`=1 and `score`=0.
- **Start edge on a tick**: raise `btn_start` in the same cycle as `frame_tick` in IDLE → `state`=1 after that tick. Holding the button does not re-trigger OVER→IDLE→PLAY.
